// File: rtl/cic_comp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cic_comp_pkg
// Brief    : Shared tap count, droop-compensation coefficients and FSM states.
// Revision : 1.0
// ============================================================================
package cic_comp_pkg;

   localparam int NTAPS     = 8;
   localparam int COEF_BITS = 16;

   // Q1.15 taps; they sum to 32768, which gives unity DC gain.
   localparam logic signed [COEF_BITS-1:0] COEF [0:NTAPS-1] = '{
      -16'sd512, 16'sd1024, -16'sd2048, 16'sd17920,
      16'sd17920, -16'sd2048, 16'sd1024, -16'sd512
   };

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MAC   = 2'd1,
      S_ROUND = 2'd2,
      S_OUT   = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/cic_comp_mac.sv
`default_nettype none
// ============================================================================
// Module   : cic_comp_mac
// Brief    : Signed multiplier feeding a clearable, enabled accumulator.
// Revision : 1.0
// ============================================================================
module cic_comp_mac #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int ACC_W  = 35
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] sample,
   input  logic [COEF_W-1:0] coef,
   output logic [ACC_W-1:0]  acc
);

   logic signed [DATA_W+COEF_W-1:0] w_prod;
   logic        [ACC_W-1:0]         r_acc;

   assign w_prod = $signed(sample) * $signed(coef);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_acc <= '0;
      end else if (en) begin
         r_acc <= r_acc + ACC_W'(w_prod);
      end
   end

   assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/cic_comp_fir.sv
`default_nettype none
// ============================================================================
// Module   : cic_comp_fir
// Brief    : Serial-MAC 8-tap CIC droop compensator with AXI-Stream in/out.
// Revision : 1.0
// ============================================================================
module cic_comp_fir
   import cic_comp_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int COEF_FRAC = 15
) (
   input  logic              aclk,
   input  logic              reset,
   input  logic [DATA_W-1:0] s_axis_data_tdata,
   input  logic              s_axis_data_tvalid,
   output logic              s_axis_data_tready,
   output logic [DATA_W-1:0] m_axis_data_tdata,
   output logic              m_axis_data_tvalid,
   input  logic              m_axis_data_tready
);

   localparam int PTR_W = $clog2(NTAPS);
   localparam int ACC_W = DATA_W + COEF_W + PTR_W;

   localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((longint'(1) <<< (DATA_W-1)) - 1);
   localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(longint'(1) <<< (DATA_W-1)));
   localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(longint'(1) <<< (COEF_FRAC-1));

   state_t             r_state;
   logic [DATA_W-1:0]  r_hist [0:NTAPS-1];
   logic [PTR_W-1:0]   r_wp;
   logic [PTR_W-1:0]   r_k;
   logic               r_s_ready;
   logic               r_m_valid;
   logic [DATA_W-1:0]  r_m_data;

   logic                     w_accept;
   logic [PTR_W-1:0]         w_wp_next;
   logic [PTR_W-1:0]         w_tap_idx;
   logic [COEF_W-1:0]        w_coef;
   logic [ACC_W-1:0]         w_acc;
   logic signed [ACC_W-1:0]  w_rounded;
   logic signed [ACC_W-1:0]  w_shifted;
   logic [DATA_W-1:0]        w_sat;

   // NTAPS is a power of two, so pointer arithmetic wraps modulo NTAPS for free.
   assign w_accept  = (r_state == S_IDLE) && r_s_ready && s_axis_data_tvalid;
   assign w_wp_next = r_wp + PTR_W'(1);
   assign w_tap_idx = r_wp - r_k;
   assign w_coef    = COEF_W'(COEF[r_k]);

   cic_comp_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk    (aclk),
      .rst    (reset),
      .clr    (w_accept),
      .en     (r_state == S_MAC),
      .sample (r_hist[w_tap_idx]),
      .coef   (w_coef),
      .acc    (w_acc)
   );

   // Round half up, then clamp to the output range.
   assign w_rounded = $signed(w_acc) + HALF;
   assign w_shifted = w_rounded >>> COEF_FRAC;

   always_comb begin
      w_sat = w_shifted[DATA_W-1:0];
      if (w_shifted > Y_MAX) begin
         w_sat = Y_MAX[DATA_W-1:0];
      end else if (w_shifted < Y_MIN) begin
         w_sat = Y_MIN[DATA_W-1:0];
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_wp      <= '0;
         r_k       <= '0;
         r_s_ready <= 1'b0;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         for (int i = 0; i < NTAPS; i++) begin
            r_hist[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               r_s_ready <= 1'b1;
               if (w_accept) begin
                  r_hist[w_wp_next] <= s_axis_data_tdata;
                  r_wp              <= w_wp_next;
                  r_k               <= '0;
                  r_s_ready         <= 1'b0;
                  r_state           <= S_MAC;
               end
            end
            S_MAC: begin
               r_k <= r_k + PTR_W'(1);
               if (r_k == PTR_W'(NTAPS-1)) begin
                  r_state <= S_ROUND;
               end
            end
            S_ROUND: begin
               r_m_data  <= w_sat;
               r_m_valid <= 1'b1;
               r_state   <= S_OUT;
            end
            S_OUT: begin
               if (m_axis_data_tready) begin
                  r_m_valid <= 1'b0;
                  r_s_ready <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign s_axis_data_tready = r_s_ready;
   assign m_axis_data_tvalid = r_m_valid;
   assign m_axis_data_tdata  = r_m_data;

endmodule
`default_nettype wire
